freq_meter: RTL and testbench
=============================

Name: freq_meter

Overview:
- Measures the frequency of an asynchronous slow input, e.g. a divided clock, button or sensor line, by counting its rising edges over a fixed gate window of system-clock cycles.
- Inverse of clock division: it turns a slow periodic signal back into a number.
- Sits beside the clock-divider logic on the 50 MHz board clock. Feeds display/readout logic with a latched count plus a one-cycle valid strobe.

Parameters:
- GATE_CYCLES, 50000000, gate window length in clock cycles (1 s at 50 MHz); must be >= 2.
- COUNT_W, 27, width of edge counter and freq_count.
- SYNC_STAGES, 2, synchronizer flops on sig_in; must be >= 2.
- Derived localparam GATE_W = $clog2(GATE_CYCLES+1).

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- sig_in  input  1  asynchronous signal under measurement.
- start  input  1  request one measurement; sampled in IDLE only.
- continuous  input  1  level: restart a gate automatically after each one ends.
- freq_count  output  COUNT_W  rising edges counted in the last completed gate.
- valid  output  1  one-cycle pulse when freq_count updates.
- busy  output  1  high while a gate is open.
- overflow  output  1  last completed gate saturated the edge counter.
- high_count  output  GATE_W  cycles sig high in last gate (optional feature).

Behaviour:
- Reset is asynchronous and active-low; the clock is single.
- On reset, every output is 0, all counters are 0, the synchronizer and edge registers are 0, and the FSM goes to IDLE.
- Sync: sig_in passes through SYNC_STAGES flops, giving sig_s. The previous value is held in sig_d. A rising edge is rise = sig_s & ~sig_d.
- Edge latency: SYNC_STAGES+1 clocks from the sig_in transition to rise being asserted.
- FSM states: IDLE, GATE, DONE.
- IDLE -> GATE when (start | continuous). On that transition gate_cnt, edge_cnt and ovf_int clear. busy=1 from the first GATE cycle.
- In GATE, on every cycle:
  - gate_cnt increments.
  - If rise: if edge_cnt equals all-ones, it holds and sets ovf_int; otherwise edge_cnt increments.
- The gate spans exactly GATE_CYCLES cycles. A rise in any of them, including the last, is counted.
- GATE -> DONE when gate_cnt == GATE_CYCLES-1.
- DONE (one cycle):
  - freq_count <= final edge_cnt; overflow <= ovf_int; valid=1.
  - If continuous=1: go straight to GATE with counters cleared. There is exactly one dead cycle between gates, and a rise in the DONE cycle is not counted.
  - Otherwise go to IDLE with busy=0.
- start while busy is ignored (not queued).
- freq_count and overflow hold their value until the next DONE.
- Reset mid-gate aborts the gate. There is no valid pulse and outputs return to 0.
- Constant input, high or low (including high from reset), gives a count of 0. An input already high at gate open is not counted.
- Dropping continuous during GATE lets the current gate finish and report, then the FSM goes to IDLE.

Optional Feature:
- Macro: FREQ_METER_DUTY_EN.
- Defined:
  - A GATE_W counter increments on each GATE cycle where sig_s=1.
  - It is latched to high_count in DONE and cleared at gate open.
  - Duty = high_count/GATE_CYCLES.
- Undefined: the counter logic is absent and high_count is tied to 0. The port list is unchanged.

Test Plan (GATE_CYCLES=100 unless stated):
- Reset, then start pulse with sig_in period 10 clocks (5 high/5 low) -> after ~101 clocks valid pulses once, freq_count=10, overflow=0, busy low afterwards.
- sig_in held high, start -> freq_count=0, valid once; start asserted during GATE -> ignored, only one valid.
- COUNT_W=3, sig_in period 4 clocks, start -> freq_count=7, overflow=1; next gate with period 50 -> freq_count=2, overflow=0.
- continuous=1, period 20 -> valid every 101 clocks, freq_count=5 each time; deassert continuous mid-gate -> one more valid, then IDLE.
- reset_n low for 3 cycles at gate cycle 50 -> outputs 0 immediately (asynchronously), no valid; new start -> correct count of 10 for period 10.
- FREQ_METER_DUTY_EN defined, period 10 at 30% high -> high_count=30 (±3 for phase); undefined -> high_count=0.

Source files
------------

// File: rtl/freq_meter.sv
// Frequency meter: counts synchronized rising edges of sig_in over a fixed
// gate window of GATE_CYCLES system clocks and reports the count with a
// one-cycle valid strobe. Single-shot on start, back-to-back gates while
// continuous is held high.
// Optional duty measurement: define FREQ_METER_DUTY_EN to count gate cycles
// with the synchronized input high and report them on high_count. Without it
// high_count is tied to zero.
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 50000000,
  parameter int unsigned COUNT_W     = 27,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned GATE_W     = $clog2(GATE_CYCLES + 1)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               sig_in,
  input  logic               start,
  input  logic               continuous,
  output logic [COUNT_W-1:0] freq_count,
  output logic               valid,
  output logic               busy,
  output logic               overflow,
  output logic [GATE_W-1:0]  high_count
);

  typedef enum logic [1:0] {StIdle, StGate, StDone} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sig_s;
  logic                   sig_d;
  logic                   rise;
  logic [GATE_W-1:0]      gate_cnt;
  logic [COUNT_W-1:0]     edge_cnt;
  logic                   ovf_int;
  logic                   gate_last;
  logic                   gate_open;

  // Bring sig_in into the clock domain and keep one cycle of history.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      sig_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      sig_d  <= sig_s;
    end
  end

  // Edge detect, gate end and gate-open decode.
  always_comb begin
    sig_s     = sync_q[SYNC_STAGES-1];
    rise      = sig_s & ~sig_d;
    gate_last = (gate_cnt == GATE_W'(GATE_CYCLES - 1));
    gate_open = ((state == StIdle) && (start || continuous)) ||
                ((state == StDone) && continuous);
  end

  // Measurement FSM with registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= StIdle;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      ovf_int    <= 1'b0;
      freq_count <= '0;
      overflow   <= 1'b0;
      valid      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        StIdle: begin
          if (gate_open) begin
            state    <= StGate;
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf_int  <= 1'b0;
            busy     <= 1'b1;
          end
        end
        StGate: begin
          gate_cnt <= gate_cnt + GATE_W'(1);
          if (rise) begin
            // Saturate rather than wrap so a too-fast input is flagged.
            if (&edge_cnt) ovf_int  <= 1'b1;
            else           edge_cnt <= edge_cnt + COUNT_W'(1);
          end
          if (gate_last) state <= StDone;
        end
        StDone: begin
          freq_count <= edge_cnt;
          overflow   <= ovf_int;
          valid      <= 1'b1;
          if (gate_open) begin
            // Back-to-back gate; this DONE cycle is the single dead cycle.
            state    <= StGate;
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf_int  <= 1'b0;
          end else begin
            state <= StIdle;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FREQ_METER_DUTY_EN
  logic [GATE_W-1:0] high_cnt;

  // Count gate cycles with the input high; latch alongside freq_count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      high_cnt   <= '0;
      high_count <= '0;
    end else begin
      if (gate_open) begin
        high_cnt <= '0;
      end else if ((state == StGate) && sig_s) begin
        high_cnt <= high_cnt + GATE_W'(1);
      end
      if (state == StDone) high_count <= high_cnt;
    end
  end
`else
  assign high_count = '0;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (wide and 3-bit counters) share the
// stimulus. The reference counts rising edges of the recorded input history
// inside each gate window, shifted by the synchronizer latency.
module tb_freq_meter;

  localparam int G    = 100;
  localparam int HMAX = 16384;

  logic        clock;
  logic        reset_n;
  logic        sig_in;
  logic        start;
  logic        continuous;
  logic [26:0] freq_count;
  logic        valid;
  logic        busy;
  logic        overflow;
  logic [6:0]  high_count;
  logic [2:0]  freq_count_s;
  logic        valid_s;
  logic        busy_s;
  logic        overflow_s;
  logic [6:0]  high_count_s;

  freq_meter #(.GATE_CYCLES(G), .COUNT_W(27), .SYNC_STAGES(2)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .sig_in     (sig_in),
    .start      (start),
    .continuous (continuous),
    .freq_count (freq_count),
    .valid      (valid),
    .busy       (busy),
    .overflow   (overflow),
    .high_count (high_count)
  );

  freq_meter #(.GATE_CYCLES(G), .COUNT_W(3), .SYNC_STAGES(2)) dut_s (
    .clock      (clock),
    .reset_n    (reset_n),
    .sig_in     (sig_in),
    .start      (start),
    .continuous (continuous),
    .freq_count (freq_count_s),
    .valid      (valid_s),
    .busy       (busy_s),
    .overflow   (overflow_s),
    .high_count (high_count_s)
  );

  typedef struct {
    int          c;
    logic [26:0] cnt;
    logic        ovf;
    logic [2:0]  scnt;
    logic        sovf;
    logic [6:0]  hc;
  } ev_t;

  ev_t ev_q[$];
  bit  hist [HMAX];
  int  cyc;
  int  per, hi, ph;
  int  vectors;
  int  miscompares;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock, log any valid strobe, then drive this cycle's input.
  task automatic step();
    ev_t e;
    @(posedge clock);
    #1;
    cyc++;
    if (valid) begin
      e.c    = cyc;
      e.cnt  = freq_count;
      e.ovf  = overflow;
      e.scnt = freq_count_s;
      e.sovf = overflow_s;
      e.hc   = high_count;
      ev_q.push_back(e);
    end
    sig_in = (((cyc + ph) % per) < hi);
    if (cyc < HMAX) hist[cyc] = sig_in;
  endtask

  // Rising edges of sig_in whose synchronized rise lands in the window.
  function automatic int exp_edges(input int open);
    int n;
    n = 0;
    for (int m = open; m < open + G; m++) if (hist[m-2] && !hist[m-3]) n++;
    return n;
  endfunction

  function automatic int exp_high(input int open);
    int n;
    n = 0;
    for (int m = open; m < open + G; m++) if (hist[m-2]) n++;
    return n;
  endfunction

  task automatic wait_valid(input int n0, input string tag);
    int k;
    k = 0;
    while (ev_q.size() <= n0 && k < G + 20) begin
      step();
      k++;
    end
    check({tag, "_valid_seen"}, 64'(ev_q.size() > n0), 1);
  endtask

  task automatic check_event(input string tag, input int idx, input int open);
    int n;
    if (idx < ev_q.size()) begin
      n = exp_edges(open);
      check({tag, "_valid_cycle"}, ev_q[idx].c, open + G + 1);
      check({tag, "_count"}, ev_q[idx].cnt, n);
      check({tag, "_ovf"}, ev_q[idx].ovf, 0);
      check({tag, "_count3"}, ev_q[idx].scnt, (n > 7) ? 7 : n);
      check({tag, "_ovf3"}, ev_q[idx].sovf, (n > 7) ? 1 : 0);
`ifdef FREQ_METER_DUTY_EN
      check({tag, "_high"}, ev_q[idx].hc, exp_high(open));
`else
      check({tag, "_high"}, ev_q[idx].hc, 0);
`endif
    end
  endtask

  task automatic run_gate(input string tag, input int p, input int h, input bit poke);
    int n0, open;
    per = p;
    hi  = h;
    ph  = $urandom_range(0, p - 1);
    repeat (8) step();
    n0    = ev_q.size();
    start = 1'b1;
    open  = cyc + 1;
    step();
    start = 1'b0;
    check({tag, "_busy_gate"}, busy, 1);
    if (poke) begin
      repeat (40) step();
      start = 1'b1;
      step();
      start = 1'b0;
    end
    wait_valid(n0, tag);
    check_event(tag, n0, open);
    check({tag, "_busy_after"}, busy, 0);
    if (poke) begin
      repeat (G + 20) step();
      check({tag, "_single_valid"}, ev_q.size(), n0 + 1);
    end
  endtask

  initial begin
    int n0, open;
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    per         = 1;
    hi          = 1;
    ph          = 0;
    sig_in      = 1'b1;
    hist[0]     = 1'b1;
    start       = 1'b0;
    continuous  = 1'b0;
    reset_n     = 1'b0;
    repeat (3) step();
    check("rst_count", freq_count, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", overflow, 0);
    check("rst_high", high_count, 0);
    reset_n = 1'b1;
    repeat (5) step();

    run_gate("p10", 10, 5, 1'b0);
    run_gate("const_high", 1, 1, 1'b1);
    run_gate("const_low", 1, 0, 1'b0);
    run_gate("p4_sat", 4, 2, 1'b0);
    run_gate("p50", 50, 25, 1'b0);
    run_gate("p2", 2, 1, 1'b0);
    run_gate("duty30", 10, 3, 1'b0);
    for (int i = 0; i < 8; i++) begin
      int p;
      p = $urandom_range(2, 60);
      run_gate($sformatf("rand%0d", i), p, $urandom_range(1, p - 1), 1'b0);
    end

    // Continuous gates, then drop continuous in the middle of the fourth.
    per = 20;
    hi  = 10;
    ph  = $urandom_range(0, 19);
    repeat (5) step();
    n0         = ev_q.size();
    continuous = 1'b1;
    open       = cyc + 1;
    step();
    for (int g = 0; g < 3; g++) begin
      wait_valid(n0 + g, $sformatf("cont%0d", g));
      check_event($sformatf("cont%0d", g), n0 + g, open);
      open = open + G + 1;
    end
    repeat (50) step();
    continuous = 1'b0;
    wait_valid(n0 + 3, "cont_last");
    check_event("cont_last", n0 + 3, open);
    repeat (G + 20) step();
    check("cont_stop_count", ev_q.size(), n0 + 4);
    check("cont_stop_busy", busy, 0);

    // Asynchronous reset in the middle of a gate.
    per   = 10;
    hi    = 5;
    repeat (5) step();
    n0    = ev_q.size();
    start = 1'b1;
    open  = cyc + 1;
    step();
    start = 1'b0;
    while (cyc < open + 50) step();
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_count", freq_count, 0);
    check("arst_count3", freq_count_s, 0);
    check("arst_busy", busy, 0);
    check("arst_valid", valid, 0);
    check("arst_ovf", overflow, 0);
    repeat (3) step();
    reset_n = 1'b1;
    repeat (G + 20) step();
    check("arst_no_valid", ev_q.size(), n0);
    run_gate("after_rst", 10, 5, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
